rsa_modexp: RTL
===============

Name: rsa_modexp

Overview:
- Downstream consumer of the key-generation inverter stage in the RS cryptosystem.
- Computes result = msg^exp mod n using constant-time right-to-left square-and-multiply.
- Used for encryption (exp = e) and decryption (exp = d). n = p*q is supplied by the key stage.
- Runs a start/busy/done handshake and holds its result until the next start.

Parameters:
WIDTH, 32, width of primes p/q and of e; modulus/message/exponent width MW = 2*WIDTH (derived localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  single-cycle request; sampled only in IDLE
msg  input  2*WIDTH  plaintext/ciphertext; latched on accepted start
exp  input  2*WIDTH  exponent (e zero-extended, or d); latched on accepted start
n  input  2*WIDTH  modulus p*q; latched on accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when result/error are valid
error  output  1  operand error flag, valid with done, held until next accepted start
result  output  2*WIDTH  msg^exp mod n, held until next accepted start

Behaviour:
- Reset (reset==0, async): state=IDLE; busy=0, done=0, error=0, result=0; operand registers cleared. Asserting reset mid-operation aborts the operation with no done pulse.
- Operands latch on the edge where start==1 in IDLE; input changes after that edge have no effect. start while busy is ignored and not queued.
- FSM:
  - IDLE -> CHECK on start.
  - CHECK: if n<2 or msg>=n -> DONE with error=1, result=0. Otherwise initialise acc=1, base=msg, bit index i=0 -> MUL.
  - MUL: two modular multipliers run in parallel for exactly MW cycles: P1 = acc*base mod n and P2 = base*base mod n. Then -> NEXT.
  - NEXT (1 cycle): acc <= exp_reg[i] ? P1 : acc; base <= P2; i <= i+1. If i==MW-1 -> DONE, else -> MUL.
  - DONE (1 cycle): done=1; result <= acc, or 0 on error; -> IDLE.
- Every exponent bit is processed, including leading zeros; no early exit (constant time).
- Latency, valid path: done is high in cycle 2 + MW*(MW+1) after the start edge. WIDTH=32 gives 4162.
- Latency, error path: done is high in cycle 2.
- busy is high from the cycle after the start edge through the DONE cycle inclusive, and low again in the following cycle. A start in that following cycle is accepted.
- exp==0 gives result 1. msg==0 with exp>0 gives result 0. 0^0 gives 1.
- Modular multiply (interleaved, MSB-first over operand a):
  - Each cycle: t = 2*acc + (a[j] ? b : 0), then subtract n up to twice so the result is < n.
  - Internal accumulator width is MW+2; no overflow is permitted.
  - Preconditions: a<n and b<n.

Decomposition:
- Shared package/header: WIDTH default, MW derivation, FSM state encodings (IDLE, CHECK, MUL, NEXT, DONE).
- Sub-module mod_mult:
  - Ports: clk, reset, start, a, b, n, done, p.
  - Fixed MW-cycle interleaved multiplier with the same reset convention.
  - Instantiated twice, one for multiply and one for square.

Test Plan:
- n=115 (23*5), msg=2, exp=3 -> done at cycle 4162, result=8, error=0, busy high for cycles 1..4162.
- n=115, msg=8, exp=59 (d for e=3, phi=88) -> result=2, confirming an encrypt/decrypt round trip. Repeat with msg=100, exp=3 then 59 -> recovers 100.
- Boundaries with n=115:
  - exp=0, msg=7 -> result=1.
  - msg=0, exp=5 -> result=0.
  - exp=1, msg=114 -> result=114.
  - n=2^64-59, msg=2^64-60, exp=2 -> result=1 (exercises max-width reduction).
- Errors: msg=115, n=115 -> done at cycle 2 with error=1, result=0. n=1 -> error=1. The next valid start clears error.
- Pulse start during busy with different operands -> ignored; the original result is delivered at the original cycle.
- Drive reset low at cycle 1000 -> busy=0, done=0, result=0 immediately (asynchronous), no done pulse. After release, a new start completes normally.

Source files
------------

// File: rtl/rsa_modexp_pkg.sv
`default_nettype none
// ============================================================================
// rsa_modexp_pkg : shared width defaults and FSM encoding for rsa_modexp
// Rev 1.0
// ============================================================================
package rsa_modexp_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Modulus, message and exponent are all twice the prime width.
  function automatic int modulus_width(input int prime_width);
    return 2 * prime_width;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MUL   = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rsa_modexp_mod_mult.sv
`default_nettype none
// ============================================================================
// mod_mult : fixed MW-cycle interleaved (MSB-first) modular multiplier, p = a*b mod n
// Rev 1.0
// ============================================================================
module mod_mult #(
  parameter int MW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  input  logic [MW-1:0] n,
  output logic          done,
  output logic [MW-1:0] p
);

  localparam int JW = $clog2(MW);

  logic [MW+1:0] acc_q, acc_d;
  logic [JW-1:0] j_q, j_d;
  logic          run_q, run_d;
  logic          done_q, done_d;
  logic [MW+1:0] n_ext, t0, t1, t2;

  // a, b and n are read directly and must stay stable (and below n) while running.
  always_comb begin
    n_ext  = {2'b00, n};
    t0     = (acc_q << 1) + (a[j_q] ? {2'b00, b} : '0);
    t1     = (t0 >= n_ext) ? (t0 - n_ext) : t0;
    t2     = (t1 >= n_ext) ? (t1 - n_ext) : t1;
    acc_d  = acc_q;
    j_d    = j_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      acc_d = '0;
      j_d   = JW'(MW - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = t2;
      j_d   = j_q - 1'b1;
      if (j_q == '0) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      j_q    <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      j_q    <= j_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = acc_q[MW-1:0];

endmodule
`default_nettype wire

// File: rtl/rsa_modexp.sv
`default_nettype none
// ============================================================================
// rsa_modexp : constant-time right-to-left square-and-multiply, result = msg^exp mod n
// Rev 1.0
// ============================================================================
module rsa_modexp
  import rsa_modexp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   msg,
  input  logic [2*WIDTH-1:0]   exp,
  input  logic [2*WIDTH-1:0]   n,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [2*WIDTH-1:0]   result
);

  localparam int MW = modulus_width(WIDTH);
  localparam int IW = $clog2(MW);

  state_e        state_q, state_d;
  logic [MW-1:0] msg_q, msg_d;
  logic [MW-1:0] exp_q, exp_d;
  logic [MW-1:0] n_q, n_d;
  logic [MW-1:0] acc_q, acc_d;
  logic [MW-1:0] base_q, base_d;
  logic [MW-1:0] result_q, result_d;
  logic          error_q, error_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          mul_start;
  logic          mul_done, sqr_done;
  logic [MW-1:0] p_mul, p_sqr;

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    exp_d     = exp_q;
    n_d       = n_q;
    acc_d     = acc_q;
    base_d    = base_q;
    result_d  = result_q;
    error_d   = error_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          msg_d    = msg;
          exp_d    = exp;
          n_d      = n;
          result_d = '0;
          error_d  = 1'b0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((n_q[MW-1:1] == '0) || (msg_q >= n_q)) begin
          error_d  = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          acc_d     = MW'(1);
          base_d    = msg_q;
          idx_d     = '0;
          cnt_d     = '0;
          mul_start = 1'b1;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IW'(MW - 1)) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (mul_done && sqr_done) begin
          acc_d  = exp_q[idx_q] ? p_mul : acc_q;
          base_d = p_sqr;
          idx_d  = idx_q + 1'b1;
          if (idx_q == IW'(MW - 1)) begin
            result_d = acc_d;
            state_d  = S_DONE;
          end else begin
            cnt_d     = '0;
            mul_start = 1'b1;
            state_d   = S_MUL;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      msg_q    <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      exp_q    <= exp_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      result_q <= result_d;
      error_q  <= error_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  // Multiply and square run in lockstep on the operands held in acc_q/base_q.
  mod_mult #(.MW(MW)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (acc_q),
    .b     (base_q),
    .n     (n_q),
    .done  (mul_done),
    .p     (p_mul)
  );

  mod_mult #(.MW(MW)) u_sqr (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (base_q),
    .b     (base_q),
    .n     (n_q),
    .done  (sqr_done),
    .p     (p_sqr)
  );

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign error  = error_q;
  assign result = result_q;

endmodule
`default_nettype wire
